// File: rtl/sram_pkg.sv
// sram_pkg: byte-width constant and clog2 helper shared by the 1R1W SRAM files
package sram_pkg;
  localparam int BW = 8;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction
endpackage

// File: rtl/sram1r1w_array.sv
// sram1r1w_array: plain DEPTH x WIDTH storage with byte-masked write and registered read
module sram1r1w_array import sram_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int AW = 1,
  parameter int NB = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] q,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [NB-1:0]    bwe
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < NB; i++)
        if (bwe[i]) mem[wa][BW*i +: BW] <= wd[BW*i +: BW];
  end
  // only the read register is reset; array contents survive reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else if (re) q <= mem[ra];
  end
endmodule

// File: rtl/sram1r1w_param.sv
// sram1r1w_param: 1R1W SRAM with range checks, write-first forwarding and valid/error flags
// Define SRAM1R1W_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module sram1r1w_param import sram_pkg::*; #(
  parameter  int DEPTH = 131072,
  parameter  int WIDTH = 32,
  localparam int AW = clog2(DEPTH),
  localparam int NB = WIDTH / BW
) (
  input  logic             CE,
  input  logic             RST,
  input  logic             CSB1,
  input  logic [AW-1:0]    A1,
  output logic [WIDTH-1:0] O1,
  output logic             V1,
  output logic             ERR1,
  input  logic             CSB2,
  input  logic             WEB2,
  input  logic [AW-1:0]    A2,
  input  logic [WIDTH-1:0] I2,
  input  logic [NB-1:0]    BWEB2
);
  localparam logic [AW:0] DL = (AW+1)'(DEPTH);
  logic r_in, w_in, rd, wr, v, e;
  logic [NB-1:0] fm;
  logic [WIDTH-1:0] fd, q, d;
  assign r_in = {1'b0, A1} < DL;
  assign w_in = {1'b0, A2} < DL;
  assign rd = ~CSB1 & ~RST;
  assign wr = ~CSB2 & ~WEB2 & w_in & ~RST;
  sram1r1w_array #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .NB(NB)) u_array (
    .clk(CE),
    .rst(RST),
    .re(rd & r_in),
    .ra(A1),
    .q(q),
    .we(wr),
    .wa(A2),
    .wd(I2),
    .bwe(~BWEB2)
  );
  // the forwarding mask is captured at the accepting edge so the merge below is write-first
  always_ff @(posedge CE or posedge RST) begin
    if (RST) begin
      v <= 1'b0;
      e <= 1'b0;
      fm <= '0;
      fd <= '0;
    end else begin
      v <= rd;
      if (rd) begin
        e <= ~r_in;
        fm <= (wr && r_in && A1 == A2) ? ~BWEB2 : '0;
        fd <= I2;
      end
    end
  end
  always_comb begin
    d = '0;
    for (int i = 0; i < NB; i++)
      d[BW*i +: BW] = e ? '0 : (fm[i] ? fd[BW*i +: BW] : q[BW*i +: BW]);
  end
`ifdef SRAM1R1W_OUTREG_EN
  always_ff @(posedge CE or posedge RST) begin
    if (RST) begin
      V1 <= 1'b0;
      ERR1 <= 1'b0;
      O1 <= '0;
    end else begin
      V1 <= v;
      if (v) begin
        ERR1 <= e;
        O1 <= d;
      end
    end
  end
`else
  assign V1 = v;
  assign ERR1 = e;
  assign O1 = d;
`endif
endmodule

// File: doc/sram1r1w_param.md
SRAM1R1W_PARAM -- requirements
Module: sram1r1w_param

Interface
REQ-001 SHALL have parameter DEPTH, default 131072, number of words (any value >= 2, need not be a power of 2).
REQ-002 SHALL have parameter WIDTH, default 32, word width in bits (multiple of 8).
REQ-003 SHALL derive localparams AW = clog2(DEPTH) and NB = WIDTH/8; these are not overridable.
REQ-004 SHALL have port CE, input, 1, the single clock; all state changes on posedge CE.
REQ-005 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port CSB1, input, 1, read select, active-low.
REQ-007 SHALL have port A1, input, AW, read address.
REQ-008 SHALL have port O1, output, WIDTH, read data.
REQ-009 SHALL have port V1, output, 1, read data valid, one-cycle pulse per accepted read.
REQ-010 SHALL have port ERR1, output, 1, out-of-range read flag, qualified by V1.
REQ-011 SHALL have port CSB2, input, 1, write select, active-low.
REQ-012 SHALL have port WEB2, input, 1, write enable, active-low.
REQ-013 SHALL have port A2, input, AW, write address.
REQ-014 SHALL have port I2, input, WIDTH, write data.
REQ-015 SHALL have port BWEB2, input, NB, per-byte write enable, active-low; bit i covers I2[8i+7:8i].

Function
REQ-016 Write SHALL occur at posedge CE when CSB2=0 and WEB2=0 and A2<DEPTH; only bytes with BWEB2[i]=0 are updated.
REQ-017 Write with A2>=DEPTH SHALL be discarded with no side effect.
REQ-018 Read SHALL be accepted at posedge CE when CSB1=0; base latency is 1 cycle: O1 and V1=1 appear after the accepting edge.
REQ-019 V1 SHALL be 1 for exactly one cycle per accepted read; back-to-back reads give V1 high every cycle.
REQ-020 O1 SHALL hold its last value while no new read completes.
REQ-021 Read and write to the same in-range address on the same edge SHALL return write-first data: written bytes from I2, unwritten bytes from the array.
REQ-022 Read with A1>=DEPTH SHALL return O1=0 with ERR1=1 alongside V1; ERR1=0 otherwise.
REQ-023 CSB1=1 SHALL leave O1, ERR1 unchanged and give V1=0 on the next cycle.
REQ-024 Write with CSB2=0, WEB2=0, BWEB2 all ones SHALL modify nothing.

Reset
REQ-025 RST=1 SHALL immediately clear O1, V1, ERR1 and all pipeline registers to 0.
REQ-026 Reset SHALL NOT clear array contents; memory is undefined until written.
REQ-027 A read in flight when RST asserts SHALL be dropped; no V1 pulse follows reset release.
REQ-028 No read or write SHALL be accepted on any edge while RST=1.

Configuration
REQ-029 Macro SRAM1R1W_OUTREG_EN SHALL, when defined, add an output register stage: read latency 2, with V1, ERR1 and O1 delayed together.
REQ-030 Without SRAM1R1W_OUTREG_EN, read latency SHALL be 1; all other behaviour is identical.
REQ-031 Forwarding (REQ-021) SHALL be resolved at the accepting edge in both configurations; the extra stage only delays the result.

Structure
REQ-032 Package sram_pkg SHALL hold the byte-width constant (8) and the clog2 helper function.
REQ-033 Storage SHALL be a sub-module, sram1r1w_array, holding the plain DEPTH x WIDTH array with byte-masked write and registered read.
REQ-034 sram1r1w_param SHALL hold range checks, forwarding, valid/error tracking and the optional output stage.

Verification
REQ-035 Reset, write 0xDEADBEEF to address 5, read address 5: O1=0xDEADBEEF, V1=1 one cycle after the read edge (two with OUTREG).
REQ-036 Address 7 holds 0x11223344; write 0xAABBCCDD with BWEB2=4'b1010; read: O1=0x11BB33DD.
REQ-037 Read and write address 9 on the same edge with data 0x0000FFFF, all bytes enabled: O1=0x0000FFFF.
REQ-038 DEPTH=100; write address 120 with 0x5; read address 120: O1=0, ERR1=1, V1=1; address 99 is unchanged.
REQ-039 Reads on 4 consecutive edges to addresses 0..3: V1 high for 4 consecutive cycles, data in order.
REQ-040 Assert RST one cycle after a read edge: V1 stays 0, O1=0, and a re-read after release returns pre-reset array data.
